// File: rtl/lpc_periph_mw.sv
// LPC peripheral decoding I/O and memory read/write cycles against NUM_WIN base/mask
// windows and forwarding hits to a backend over a req/ready handshake with long-wait SYNC.
//
// state   | meaning
// IDLE    | waiting for START (LFRAME# low, LAD=0)
// CYCTYPE | sampling cycle type and direction
// ADDR    | shifting in address nibbles, MSB first
// WDATA   | shifting in write data, low nibble first
// TARH1   | host turnaround 1, backend request strobe
// TARH2   | host turnaround 2, first clock ready_i is honoured
// SYNC    | driving long-wait (6), ready (0) or error (A)
// PDATA   | driving read data, low nibble then high nibble
// TARP1   | driving F before releasing LAD
// TARP2   | LAD released, back to IDLE
module lpc_periph_mw #(
    parameter int                    NUM_WIN  = 2,
    parameter logic [NUM_WIN*32-1:0] WIN_BASE = {32'h0000_0F00, 32'h0000_0080},
    parameter logic [NUM_WIN*32-1:0] WIN_MASK = {32'h0000_FFF0, 32'h0000_FFFF},
    parameter logic [NUM_WIN-1:0]    WIN_MEM  = 2'b00,
    parameter int                    MAX_WAIT = 16
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        lframe_i,
    input  logic [3:0]  lad_i,
    output logic [3:0]  lad_o,
    output logic        lad_oe_o,
    output logic        req_o,
    output logic        wr_o,
    output logic        mem_o,
    output logic [31:0] addr_o,
    output logic [7:0]  wdata_o,
    output logic [2:0]  win_o,
    input  logic        ready_i,
    input  logic [7:0]  rdata_i,
    output logic        err_o,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CYCTYPE = 4'd1,
        S_ADDR    = 4'd2,
        S_WDATA   = 4'd3,
        S_TARH1   = 4'd4,
        S_TARH2   = 4'd5,
        S_SYNC    = 4'd6,
        S_PDATA   = 4'd7,
        S_TARP1   = 4'd8,
        S_TARP2   = 4'd9
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
    localparam logic [3:0] SYNC_READY = 4'h0;
    localparam logic [3:0] SYNC_LWAIT = 4'h6;
    localparam logic [3:0] SYNC_ERR   = 4'hA;

    state_t      state_q, state_d;
    logic [2:0]  nib_q, nib_d;
    logic        cyc_wr_q, cyc_wr_d;
    logic        cyc_mem_q, cyc_mem_d;
    logic [31:0] addr_sh_q, addr_sh_d;
    logic [3:0]  wd_lo_q, wd_lo_d;
    logic [2:0]  hit_win_q, hit_win_d;
    logic [7:0]  wait_q, wait_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [3:0]  lad_q, lad_d;
    logic        lad_oe_q, lad_oe_d;
    logic        req_q, req_d;
    logic        err_q, err_d;
    logic        wr_q, wr_d;
    logic        mem_q, mem_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [2:0]  win_q, win_d;

    logic [31:0] addr_full;
    logic        hit;
    logic [2:0]  hit_idx;

    // Shift register is cleared at CYCTYPE, so I/O addresses come out zero-extended.
    assign addr_full = {addr_sh_q[27:0], lad_i};

    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int n = NUM_WIN - 1; n >= 0; n--) begin
            if ((WIN_MEM[n] == cyc_mem_q) &&
                (((addr_full ^ WIN_BASE[32*n +: 32]) & WIN_MASK[32*n +: 32]) == 32'd0)) begin
                hit     = 1'b1;
                hit_idx = 3'(n);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        nib_d     = nib_q;
        cyc_wr_d  = cyc_wr_q;
        cyc_mem_d = cyc_mem_q;
        addr_sh_d = addr_sh_q;
        wd_lo_d   = wd_lo_q;
        hit_win_d = hit_win_q;
        wait_d    = wait_q;
        rdata_d   = rdata_q;
        lad_d     = lad_q;
        lad_oe_d  = lad_oe_q;
        req_d     = 1'b0;
        err_d     = 1'b0;
        wr_d      = wr_q;
        mem_d     = mem_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        win_d     = win_q;

        if (!lframe_i) begin
            lad_oe_d = 1'b0;
            lad_d    = 4'hF;
            state_d  = (lad_i == 4'h0) ? S_CYCTYPE : S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_CYCTYPE: begin
                    if (!lad_i[3]) begin
                        cyc_wr_d  = lad_i[1];
                        cyc_mem_d = lad_i[2];
                        nib_d     = lad_i[2] ? 3'd7 : 3'd3;
                        addr_sh_d = 32'd0;
                        wait_d    = 8'd0;
                        state_d   = S_ADDR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ADDR: begin
                    addr_sh_d = addr_full;
                    if (nib_q != 3'd0) begin
                        nib_d = nib_q - 3'd1;
                    end else if (!hit) begin
                        state_d = S_IDLE;
                    end else if (cyc_wr_q) begin
                        hit_win_d = hit_idx;
                        nib_d     = 3'd1;
                        state_d   = S_WDATA;
                    end else begin
                        req_d   = 1'b1;
                        wr_d    = 1'b0;
                        mem_d   = cyc_mem_q;
                        addr_d  = addr_full;
                        win_d   = hit_idx;
                        state_d = S_TARH1;
                    end
                end
                S_WDATA: begin
                    if (nib_q != 3'd0) begin
                        wd_lo_d = lad_i;
                        nib_d   = 3'd0;
                    end else begin
                        req_d   = 1'b1;
                        wr_d    = 1'b1;
                        mem_d   = cyc_mem_q;
                        addr_d  = addr_sh_q;
                        win_d   = hit_win_q;
                        wdata_d = {lad_i, wd_lo_q};
                        state_d = S_TARH1;
                    end
                end
                S_TARH1: state_d = S_TARH2;
                S_TARH2: begin
                    state_d  = S_SYNC;
                    lad_oe_d = 1'b1;
                    if (ready_i) begin
                        rdata_d = rdata_i;
                        lad_d   = SYNC_READY;
                    end else begin
                        lad_d  = SYNC_LWAIT;
                        wait_d = 8'd1;
                    end
                end
                S_SYNC: begin
                    // Only a long-wait SYNC is followed by another SYNC clock.
                    if (lad_q == SYNC_LWAIT) begin
                        if (ready_i) begin
                            rdata_d = rdata_i;
                            lad_d   = SYNC_READY;
                        end else if (wait_q == WAIT_LIMIT) begin
                            rdata_d = 8'hFF;
                            lad_d   = SYNC_ERR;
                            err_d   = 1'b1;
                        end else begin
                            wait_d = wait_q + 8'd1;
                        end
                    end else if (cyc_wr_q) begin
                        lad_d   = 4'hF;
                        state_d = S_TARP1;
                    end else begin
                        lad_d   = rdata_q[3:0];
                        nib_d   = 3'd1;
                        state_d = S_PDATA;
                    end
                end
                S_PDATA: begin
                    if (nib_q != 3'd0) begin
                        lad_d = rdata_q[7:4];
                        nib_d = 3'd0;
                    end else begin
                        lad_d   = 4'hF;
                        state_d = S_TARP1;
                    end
                end
                S_TARP1: begin
                    lad_oe_d = 1'b0;
                    lad_d    = 4'hF;
                    state_d  = S_TARP2;
                end
                S_TARP2: state_d = S_IDLE;
                default: begin
                    lad_oe_d = 1'b0;
                    lad_d    = 4'hF;
                    state_d  = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q   <= S_IDLE;
            nib_q     <= 3'd0;
            cyc_wr_q  <= 1'b0;
            cyc_mem_q <= 1'b0;
            addr_sh_q <= 32'd0;
            wd_lo_q   <= 4'd0;
            hit_win_q <= 3'd0;
            wait_q    <= 8'd0;
            rdata_q   <= 8'd0;
            lad_q     <= 4'hF;
            lad_oe_q  <= 1'b0;
            req_q     <= 1'b0;
            err_q     <= 1'b0;
            wr_q      <= 1'b0;
            mem_q     <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 8'd0;
            win_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            nib_q     <= nib_d;
            cyc_wr_q  <= cyc_wr_d;
            cyc_mem_q <= cyc_mem_d;
            addr_sh_q <= addr_sh_d;
            wd_lo_q   <= wd_lo_d;
            hit_win_q <= hit_win_d;
            wait_q    <= wait_d;
            rdata_q   <= rdata_d;
            lad_q     <= lad_d;
            lad_oe_q  <= lad_oe_d;
            req_q     <= req_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            mem_q     <= mem_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            win_q     <= win_d;
        end
    end

    assign lad_o    = lad_q;
    assign lad_oe_o = lad_oe_q;
    assign req_o    = req_q;
    assign err_o    = err_q;
    assign wr_o     = wr_q;
    assign mem_o    = mem_q;
    assign addr_o   = addr_q;
    assign wdata_o  = wdata_q;
    assign win_o    = win_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_lpc_periph_mw.sv
// Bench for lpc_periph_mw: two instances (I/O windows, mixed memory/I/O windows) checked
// clock by clock against an expected LAD/req/err trace built from the protocol rules.
module tb_lpc_periph_mw;

    localparam int MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        nrst;
    logic        lframe;
    logic [3:0]  lad_in;
    logic        ready;
    logic [7:0]  rdata;

    logic [3:0]  lad_a, lad_m, st_a, st_m;
    logic        oe_a, oe_m, req_a, req_m, wr_a, wr_m, mem_a, mem_m, err_a, err_m;
    logic [31:0] addr_a, addr_m;
    logic [7:0]  wd_a, wd_m;
    logic [2:0]  win_a, win_m;

    int sel = 0;
    int errs = 0;
    int checks = 0;

    logic [31:0] cfg_base [2][2];
    logic [31:0] cfg_mask [2][2];
    bit          cfg_mem  [2][2];
    logic [6:0]  exp_q[$];

    always #5 clk = ~clk;

    lpc_periph_mw dut_a (
        .clk_i(clk), .nrst_i(nrst), .lframe_i(lframe), .lad_i(lad_in),
        .lad_o(lad_a), .lad_oe_o(oe_a), .req_o(req_a), .wr_o(wr_a), .mem_o(mem_a),
        .addr_o(addr_a), .wdata_o(wd_a), .win_o(win_a), .ready_i(ready),
        .rdata_i(rdata), .err_o(err_a), .state_o(st_a)
    );

    lpc_periph_mw #(
        .NUM_WIN (2),
        .WIN_BASE({32'h0000_0F00, 32'h000F_FFC0}),
        .WIN_MASK({32'h0000_FFF0, 32'hFFFF_FFF0}),
        .WIN_MEM (2'b01),
        .MAX_WAIT(MAX_WAIT)
    ) dut_m (
        .clk_i(clk), .nrst_i(nrst), .lframe_i(lframe), .lad_i(lad_in),
        .lad_o(lad_m), .lad_oe_o(oe_m), .req_o(req_m), .wr_o(wr_m), .mem_o(mem_m),
        .addr_o(addr_m), .wdata_o(wd_m), .win_o(win_m), .ready_i(ready),
        .rdata_i(rdata), .err_o(err_m), .state_o(st_m)
    );

    logic [3:0]  lad_s;
    logic        oe_s, req_s, wr_s, mem_s, err_s;
    logic [31:0] addr_s;
    logic [7:0]  wd_s;
    logic [2:0]  win_s;

    assign lad_s  = (sel == 1) ? lad_m  : lad_a;
    assign oe_s   = (sel == 1) ? oe_m   : oe_a;
    assign req_s  = (sel == 1) ? req_m  : req_a;
    assign wr_s   = (sel == 1) ? wr_m   : wr_a;
    assign mem_s  = (sel == 1) ? mem_m  : mem_a;
    assign err_s  = (sel == 1) ? err_m  : err_a;
    assign addr_s = (sel == 1) ? addr_m : addr_a;
    assign wd_s   = (sel == 1) ? wd_m   : wd_a;
    assign win_s  = (sel == 1) ? win_m  : win_a;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // LAD is only meaningful while driven, so it is masked to 0 when oe is low.
    function automatic logic [6:0] pk(input logic oe, input logic [3:0] l, input logic rq, input logic er);
        return {oe, (oe ? l : 4'h0), rq, er};
    endfunction

    function automatic bit model_hit(input int s, input bit mem, input logic [31:0] a, output logic [2:0] w);
        bit h;
        h = 1'b0;
        w = 3'd0;
        for (int n = 0; n < 2; n++) begin
            if (!h && cfg_mem[s][n] == mem && (a & cfg_mask[s][n]) == (cfg_base[s][n] & cfg_mask[s][n])) begin
                h = 1'b1;
                w = 3'(n);
            end
        end
        return h;
    endfunction

    task automatic start_frame();
        @(negedge clk);
        lframe = 1'b0;
        lad_in = 4'h0;
    endtask

    task automatic send_body(input logic [3:0] cyc, input logic [31:0] addr, input logic [7:0] wd);
        int n;
        @(negedge clk);
        ready  = 1'b0;
        lframe = 1'b1;
        lad_in = cyc;
        n = cyc[2] ? 8 : 4;
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            lad_in = addr[4*i +: 4];
        end
        if (!cyc[3] && cyc[1]) begin
            @(negedge clk);
            lad_in = wd[3:0];
            @(negedge clk);
            lad_in = wd[7:4];
        end
    endtask

    // d = clock (counted from the req_o clock) on which ready_i is high; 0 = never.
    task automatic check_trace(input logic [3:0] cyc, input logic [31:0] addr, input logic [7:0] wd,
                               input int d, input logic [7:0] rd);
        bit         wr, mem, hit, tmo;
        logic [2:0] w;
        logic [31:0] ea;
        logic [7:0] dv;
        int         sixes;
        wr  = cyc[1];
        mem = cyc[2];
        ea  = mem ? addr : {16'h0, addr[15:0]};
        hit = model_hit(sel, mem, ea, w);
        if (cyc[3]) hit = 1'b0;
        exp_q.delete();
        if (!hit) begin
            repeat (6) exp_q.push_back(pk(1'b0, 4'hF, 1'b0, 1'b0));
        end else begin
            tmo   = (d == 0) || (d > MAX_WAIT + 1);
            sixes = tmo ? MAX_WAIT : d - 1;
            dv    = tmo ? 8'hFF : rd;
            exp_q.push_back(pk(1'b0, 4'hF, 1'b1, 1'b0));
            exp_q.push_back(pk(1'b0, 4'hF, 1'b0, 1'b0));
            repeat (sixes) exp_q.push_back(pk(1'b1, 4'h6, 1'b0, 1'b0));
            exp_q.push_back(tmo ? pk(1'b1, 4'hA, 1'b0, 1'b1) : pk(1'b1, 4'h0, 1'b0, 1'b0));
            if (!wr) begin
                exp_q.push_back(pk(1'b1, dv[3:0], 1'b0, 1'b0));
                exp_q.push_back(pk(1'b1, dv[7:4], 1'b0, 1'b0));
            end
            exp_q.push_back(pk(1'b1, 4'hF, 1'b0, 1'b0));
            exp_q.push_back(pk(1'b0, 4'hF, 1'b0, 1'b0));
            exp_q.push_back(pk(1'b0, 4'hF, 1'b0, 1'b0));
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check_val($sformatf("trace[%0d] sel%0d cyc%0h a%0h", i, sel, cyc, ea),
                      64'(pk(oe_s, lad_s, req_s, err_s)), 64'(exp_q[i]));
            if (hit && i == 0) begin
                check_val("addr_o", 64'(addr_s), 64'(ea));
                check_val("wr_o", 64'(wr_s), 64'(wr));
                check_val("mem_o", 64'(mem_s), 64'(mem));
                check_val("win_o", 64'(win_s), 64'(w));
                if (wr) check_val("wdata_o", 64'(wd_s), 64'(wd));
            end
            lframe = 1'b1;
            lad_in = 4'hF;
            ready  = hit && d != 0 && i == d;
            rdata  = ready ? rd : 8'($urandom);
        end
        ready = 1'b0;
    endtask

    task automatic run(input int s, input logic [3:0] cyc, input logic [31:0] addr,
                       input logic [7:0] wd, input int d, input logic [7:0] rd);
        sel = s;
        start_frame();
        send_body(cyc, addr, wd);
        check_trace(cyc, addr, wd, d, rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  cyc;
        logic [31:0] a;
        int          s, n;
        cfg_base[0][0] = 32'h0000_0080; cfg_mask[0][0] = 32'h0000_FFFF; cfg_mem[0][0] = 1'b0;
        cfg_base[0][1] = 32'h0000_0F00; cfg_mask[0][1] = 32'h0000_FFF0; cfg_mem[0][1] = 1'b0;
        cfg_base[1][0] = 32'h000F_FFC0; cfg_mask[1][0] = 32'hFFFF_FFF0; cfg_mem[1][0] = 1'b1;
        cfg_base[1][1] = 32'h0000_0F00; cfg_mask[1][1] = 32'h0000_FFF0; cfg_mem[1][1] = 1'b0;

        nrst = 1'b0; lframe = 1'b1; lad_in = 4'hF; ready = 1'b0; rdata = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst lad_oe_o", 64'(oe_a), 64'(0));
        check_val("rst lad_o", 64'(lad_a), 64'(4'hF));
        check_val("rst req/err/wr/mem", 64'({req_a, err_a, wr_a, mem_a}), 64'(0));
        check_val("rst addr_o", 64'(addr_a), 64'(0));
        check_val("rst wdata/win", 64'({wd_a, win_a}), 64'(0));
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 4'h2, 32'h0000_0F05, 8'h5A, 1, 8'h00);
        run(0, 4'h0, 32'h0000_0080, 8'h00, 3, 8'hA5);
        run(0, 4'h0, 32'h0000_0100, 8'h00, 1, 8'h00);
        run(0, 4'h0, 32'h0000_0080, 8'h00, 0, 8'h00);
        run(0, 4'h2, 32'h0000_0F0C, 8'h81, MAX_WAIT + 1, 8'h00);
        run(0, 4'h0, 32'h0000_0F00, 8'h00, MAX_WAIT + 1, 8'h3C);
        run(0, 4'h0, 32'h0000_0F00, 8'h00, MAX_WAIT + 2, 8'h3C);
        run(0, 4'h6, 32'h0000_0080, 8'h11, 1, 8'h00);
        run(0, 4'hE, 32'h0000_0080, 8'h00, 1, 8'h00);

        sel = 0;
        start_frame();
        send_body(4'h0, 32'h0000_0080, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lad_in = 4'hF;
            if (i == 0) check_val("abort req_o", 64'(req_a), 64'(1));
            if (i >= 2) check_val($sformatf("abort sync[%0d]", i), 64'({oe_a, lad_a}), 64'(5'h16));
        end
        lframe = 1'b0;
        lad_in = 4'h0;
        @(negedge clk);
        check_val("abort lad_oe_o", 64'(oe_a), 64'(0));
        ready = 1'b1;
        rdata = 8'h11;
        send_body(4'h2, 32'h0000_0F05, 8'hC3);
        check_trace(4'h2, 32'h0000_0F05, 8'hC3, 2, 8'h00);

        run(1, 4'h6, 32'h000F_FFC0, 8'h3C, 1, 8'h00);
        run(1, 4'h2, 32'h000F_FFC0, 8'h3C, 1, 8'h00);
        run(1, 4'h4, 32'h000F_FFC7, 8'h00, 2, 8'h9E);
        run(1, 4'h2, 32'h0000_0F0A, 8'h42, 1, 8'h00);

        for (int k = 0; k < 40; k++) begin
            s = int'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) cyc = 4'h8 | 4'($urandom_range(0, 7));
            else cyc = {1'b0, 3'($urandom_range(0, 7))};
            n = int'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) a = $urandom;
            else a = (cfg_base[s][n] & cfg_mask[s][n]) | ($urandom & ~cfg_mask[s][n]);
            run(s, cyc, a, 8'($urandom), int'($urandom_range(0, 20)), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/lpc_periph_mw.md
Name: lpc_periph_mw

Overview:
Parametrised successor to the single-window LPC peripheral. It decodes LPC I/O and memory read/write cycles against NUM_WIN base/mask windows. Matching cycles are forwarded to a backend over a req/ready handshake, with long-wait SYNC insertion and a timeout error SYNC. The block sits between the LPC pins, which a top-level tri-state buffer drives from lad_o/lad_oe_o, and per-function register blocks.

Parameters:
NUM_WIN, 2, number of decode windows (1..8)
WIN_BASE, {32'h0000_0F00, 32'h0000_0080}, flat NUM_WIN*32 vector; window n uses bits [32n+31:32n]
WIN_MASK, {32'h0000_FFF0, 32'h0000_FFFF}, flat NUM_WIN*32; address bits compared where mask bit is 1
WIN_MEM, 2'b00, NUM_WIN bits; 1 = window decodes memory cycles, 0 = I/O cycles
MAX_WAIT, 16, long-wait SYNC cycles allowed before error SYNC (1..255)

Ports:
clk_i  in  1  LPC clock (LCLK)
nrst_i  in  1  asynchronous active-low reset (LRESET#)
lframe_i  in  1  active-low LFRAME#
lad_i  in  4  LAD sampled from pins
lad_o  out  4  LAD value to drive
lad_oe_o  out  1  LAD output enable
req_o  out  1  one-cycle backend request strobe
wr_o  out  1  1 = write, 0 = read; valid with req_o
mem_o  out  1  1 = memory cycle; valid with req_o
addr_o  out  32  cycle address; I/O cycles zero-extended from 16 bits
wdata_o  out  8  write data
win_o  out  3  index of the hit window (lowest index wins)
ready_i  in  1  backend completion, sampled from the cycle after req_o
rdata_i  in  8  read data, valid while ready_i=1
err_o  out  1  one-cycle pulse on timeout error SYNC
state_o  out  4  current FSM state (debug)

Behaviour:
- Reset (async, nrst_i=0): state IDLE; lad_oe_o=0; lad_o=4'hF; req_o, err_o, wr_o, mem_o=0; addr_o, wdata_o, win_o=0; wait counter=0.
- START: any clock with lframe_i=0 and lad_i=4'h0 -> CYCTYPE next. lframe_i=0 with any other lad_i -> IDLE (abort/ignore). This check applies in every state, including mid-cycle and while driving; lad_oe_o drops the same clock.
- CYCTYPE lad_i[3:1]: 000 IO rd, 001 IO wr, 010 MEM rd, 011 MEM wr -> ADDR with nibble count 4 (IO) or 8 (MEM). Any other value (DMA, FW, reserved) -> IDLE.
- ADDR: nibbles arrive MSB first. After the last nibble, evaluate hit = any n with WIN_MEM[n]==mem and ((addr ^ BASE_n) & MASK_n)==0.
  - Miss -> IDLE; LAD is never driven.
  - Hit and write -> WDATA.
  - Hit and read -> TARH1.
- WDATA: 2 nibbles, low nibble first -> TARH1.
- TARH1: req_o=1 for exactly this clock; wr_o/mem_o/addr_o/win_o/wdata_o stable from here until the next req_o.
- TARH2 -> SYNC; lad_oe_o asserts at SYNC.
- SYNC: done flag = ready_i seen on any clock from TARH2 onward.
  - Done -> drive 4'h0, then PDATA (read) or TARP1 (write).
  - Not done -> drive 4'h6 and increment the wait counter.
  - Counter == MAX_WAIT -> drive 4'hA for one clock, err_o pulse, then PDATA (read) or TARP1 (write).
- rdata_i is captured on the ready_i clock. On error, read data is 8'hFF.
- PDATA: drive low nibble, then high nibble -> TARP1.
- TARP1: drive 4'hF. TARP2: lad_oe_o=0 -> IDLE. Total = 2 TAR clocks.
- Backend receives no further req_o until the current cycle ends or aborts. A late ready_i after abort or error is ignored.
- Latency with ready_i high the clock after req_o:
  - IO write: 13 clocks START..TARP2.
  - IO read: 13 clocks.
  - Memory cycles: 4 more clocks each.

Test Plan:
- IO write 0x0F05 data 0x5A, ready_i 1 clock after req_o: req_o once, wr_o=1, addr_o=0x00000F05, wdata_o=0x5A, win_o=1; LAD SYNC 0 then F; lad_oe_o released at TARP2.
- IO read 0x0080, ready_i after 3 clocks with rdata_i=0xA5: SYNC 6,6,0; data nibbles 5 then A; win_o=0.
- IO read 0x0100 (miss): no req_o; lad_oe_o stays 0; back to IDLE after address.
- Backend never answers (MAX_WAIT=16): 16 clocks of SYNC 6, one 4'hA, err_o pulse, read data nibbles F,F.
- lframe_i=0 with lad_i=0 during the second SYNC clock: lad_oe_o=0 next clock; new cycle decoded normally; late ready_i ignored.
- Memory write 0x000FFFC0 with WIN_MEM=2'b01, WIN_BASE[0]=0x000FFFC0: hit on window 0, mem_o=1; the same address as an IO cycle misses.
